// File: rtl/manchester_framer_if.sv
// AXI-Stream style word channel shared by the framer's payload input and header/payload output.
// The slave view leaves tuser out because upstream payload carries no sideband.
`timescale 1ns/1ps
interface manchester_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/manchester_framer.sv
// Prepends preamble and SFD words to each payload frame ahead of the Manchester encoder.
// Also enforces an inter-frame gap, supports a per-frame header bypass and counts completed frames.
`timescale 1ns/1ps
module manchester_framer #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    PREAMBLE_LEN  = 3,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD = 'hAA,
    parameter logic [DATA_WIDTH-1:0] SFD_WORD      = 'hD5,
    parameter int                    IFG_LEN       = 2,
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    manchester_framer_if.slave   s_axis,
    manchester_framer_if.master  m_axis,
    input  logic                 cfg_bypass,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_GAP
    } state_t;

    localparam logic [7:0] PRE_INIT = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] GAP_INIT = 8'((IFG_LEN > 0) ? IFG_LEN - 1 : 0);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    last_taken_q, last_taken_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;

    logic s_ready;
    logic m_hs;
    logic s_hs;

    assign s_ready = (state_q == S_DATA) && !last_taken_q && (!tvalid_q || m_axis.tready);
    assign m_hs    = tvalid_q && m_axis.tready;
    assign s_hs    = s_axis.tvalid && s_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_taken_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_taken_q <= last_taken_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_taken_d = last_taken_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                // The bypass choice is made once here and held for the whole frame.
                if (s_axis.tvalid) begin
                    if (cfg_bypass) begin
                        tvalid_d = 1'b0;
                        state_d  = S_DATA;
                    end else begin
                        tdata_d  = PREAMBLE_WORD;
                        tuser_d  = 1'b1;
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b1;
                        cnt_d    = PRE_INIT;
                        state_d  = S_PREAMBLE;
                    end
                end
            end
            S_PREAMBLE: begin
                if (m_hs) begin
                    if (cnt_q == 8'd0) begin
                        tdata_d = SFD_WORD;
                        tuser_d = 1'b1;
                        state_d = S_SFD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_SFD: begin
                if (m_hs) begin
                    tvalid_d = 1'b0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (s_hs) begin
                    tdata_d  = s_axis.tdata;
                    tlast_d  = s_axis.tlast;
                    tuser_d  = 1'b0;
                    tvalid_d = 1'b1;
                    if (s_axis.tlast) begin
                        last_taken_d = 1'b1;
                    end
                end else if (m_hs) begin
                    tvalid_d = 1'b0;
                end
                // Input is already blocked by last_taken, so no new word can collide with this.
                if (m_hs && tlast_q) begin
                    frame_cnt_d  = frame_cnt_q + CNT_WIDTH'(1);
                    last_taken_d = 1'b0;
                    if (IFG_LEN > 0) begin
                        cnt_d   = GAP_INIT;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign frame_count   = frame_cnt_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_manchester_framer.sv
// Bench for manchester_framer: a queue of expected output words built from the framing rules
// is compared against every output handshake, alongside literal latency and count expectations.
`timescale 1ns/1ps
module tb_manchester_framer;
    localparam int DW   = 8;
    localparam int PLEN = 3;
    localparam int IFG  = 2;
    localparam int CW   = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_bypass;
    logic [CW-1:0] frame_count;
    logic          busy;
    logic          cfgBypassB;
    logic [1:0]    frameCountB;
    logic          busyB;

    manchester_framer_if #(.DATA_WIDTH(DW)) s_if ();
    manchester_framer_if #(.DATA_WIDTH(DW)) m_if ();
    manchester_framer_if #(.DATA_WIDTH(DW)) sB_if ();
    manchester_framer_if #(.DATA_WIDTH(DW)) mB_if ();

    manchester_framer #(.DATA_WIDTH(DW), .PREAMBLE_LEN(PLEN), .IFG_LEN(IFG), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
        .cfg_bypass(cfg_bypass), .frame_count(frame_count), .busy(busy)
    );

    manchester_framer #(.DATA_WIDTH(DW), .PREAMBLE_LEN(1), .IFG_LEN(IFG), .CNT_WIDTH(2)) dutSmall (
        .aclk(aclk), .aresetn(aresetn), .s_axis(sB_if), .m_axis(mB_if),
        .cfg_bypass(cfgBypassB), .frame_count(frameCountB), .busy(busyB)
    );

    always #5 aclk = ~aclk;

    int    vectors = 0;
    int    fails = 0;
    int    cyc = 0;
    int    expCount = 0;
    int    readyPct = 100;
    int    idleRun = 0;
    int    lastGap = 0;
    int    firstValidCyc = 0;
    int    startCyc = 0;
    int    firstAcceptCyc = 0;
    logic  checkEn = 1'b1;
    logic  watch = 1'b0;
    logic  prevStall = 1'b0;
    logic  afterLast = 1'b0;
    beat_t curBeat;
    beat_t prevBeat;
    beat_t expQ[$];
    beat_t logQ[$];
    int    logCyc[$];
    beat_t logB[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready, randomised by readyPct and changed just after each rising edge.
    always @(posedge aclk) begin
        #1;
        m_if.tready = ($urandom_range(99) < readyPct);
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            expQ.delete();
            expCount  = 0;
            prevStall = 1'b0;
            afterLast = 1'b0;
            idleRun   = 0;
        end else if (checkEn) begin
            curBeat = {m_if.tdata, m_if.tuser, m_if.tlast};
            if (prevStall) begin
                checkOutput("stall_hold_valid", 32'(m_if.tvalid), 32'd1);
                checkOutput("stall_hold_word", 32'(curBeat), 32'(prevBeat));
            end
            checkOutput("frame_count", 32'(frame_count), 32'(expCount));
            if (m_if.tvalid) begin
                if (watch) begin
                    firstValidCyc = cyc;
                    watch = 1'b0;
                end
                if (afterLast) begin
                    lastGap = idleRun;
                    checkOutput("ifg_min", 32'(idleRun >= IFG + 1), 32'd1);
                    afterLast = 1'b0;
                end
            end else if (afterLast) begin
                idleRun++;
            end
            if (m_if.tvalid && m_if.tready) begin
                logQ.push_back(curBeat);
                logCyc.push_back(cyc);
                if (expQ.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no word", curBeat);
                end else begin
                    checkOutput("stream_word", 32'(curBeat), 32'(expQ.pop_front()));
                end
                if (m_if.tlast) begin
                    expCount  = (expCount + 1) % (1 << CW);
                    afterLast = 1'b1;
                    idleRun   = 0;
                end
            end
            prevStall = m_if.tvalid && !m_if.tready;
            prevBeat  = curBeat;
        end
    end

    always @(negedge aclk) begin
        if (aresetn && mB_if.tvalid && mB_if.tready) begin
            logB.push_back({mB_if.tdata, mB_if.tuser, mB_if.tlast});
        end
    end

    task automatic waitAccept(output int accCyc);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        accCyc = -1;
        while (!got && n < 500) begin
            @(negedge aclk);
            got = s_if.tready;
            if (got) accCyc = cyc;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while ((expQ.size() != 0 || busy) && n < 2000);
        checkOutput("drain_timeout", 32'(expQ.size() == 0 && !busy), 32'd1);
        @(posedge aclk);
        #1;
    endtask

    // Sends one frame upstream and appends the words it must produce downstream to the model.
    task automatic applyStimulus(input logic [7:0] words[$], input logic bypass,
                                 input int gapPct, input logic toggleBypass);
        int acc;
        int n;
        n = words.size();
        if (!bypass) begin
            for (int p = 0; p < PLEN; p++) expQ.push_back({8'hAA, 1'b1, 1'b0});
            expQ.push_back({8'hD5, 1'b1, 1'b0});
        end
        for (int i = 0; i < n; i++) expQ.push_back({words[i], 1'b0, 1'(i == n - 1)});
        cfg_bypass = bypass;
        for (int i = 0; i < n; i++) begin
            if (gapPct > 0 && $urandom_range(99) < gapPct) begin
                s_if.tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            s_if.tdata  = words[i];
            s_if.tlast  = (i == n - 1);
            s_if.tvalid = 1'b1;
            if (i == 0) startCyc = cyc;
            waitAccept(acc);
            if (i == 0) begin
                firstAcceptCyc = acc;
                if (toggleBypass) cfg_bypass = ~bypass;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    initial begin
        logic [7:0] w[$];
        logic [7:0] litData[7];
        logic       litUser[7];
        int         litCyc[7];
        int         smallCnt[5];
        int         n;
        logic [1:0] prevB;

        litData  = '{8'hAA, 8'hAA, 8'hAA, 8'hD5, 8'h11, 8'h22, 8'h33};
        litUser  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        litCyc   = '{1, 2, 3, 4, 6, 7, 8};
        smallCnt = '{1, 2, 3, 0, 1};

        aresetn = 1'b0;
        cfg_bypass = 1'b0;
        cfgBypassB = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        sB_if.tvalid = 1'b0; sB_if.tdata = '0; sB_if.tlast = 1'b0; sB_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        mB_if.tready = 1'b1;
        #12;
        checkOutput("reset_tvalid", 32'(m_if.tvalid), 32'd0);
        checkOutput("reset_tdata", 32'(m_if.tdata), 32'd0);
        checkOutput("reset_tlast_tuser", 32'({m_if.tlast, m_if.tuser}), 32'd0);
        checkOutput("reset_s_tready", 32'(s_if.tready), 32'd0);
        checkOutput("reset_busy_count", 32'({busy, frame_count}), 32'd0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        $display("[TB] basic frame with header");
        logQ.delete(); logCyc.delete();
        watch = 1'b1;
        w = '{8'h11, 8'h22, 8'h33};
        applyStimulus(w, 1'b0, 0, 1'b0);
        waitIdle();
        checkOutput("hdr_first_valid", 32'(firstValidCyc - startCyc), 32'd1);
        checkOutput("hdr_first_accept", 32'(firstAcceptCyc - startCyc), 32'(PLEN + 2));
        checkOutput("lit_size", 32'(logQ.size()), 32'd7);
        for (int i = 0; i < 7 && i < logQ.size(); i++) begin
            checkOutput("lit_word", 32'(logQ[i]), 32'({litData[i], litUser[i], 1'(i == 6)}));
            checkOutput("lit_cycle", 32'(logCyc[i] - startCyc), 32'(litCyc[i]));
        end
        checkOutput("lit_count", 32'(frame_count), 32'd1);

        $display("[TB] same frame under random backpressure");
        readyPct = 50;
        applyStimulus(w, 1'b0, 0, 1'b0);
        waitIdle();
        readyPct = 100;

        $display("[TB] back-to-back frames and gap length");
        w = '{8'h01, 8'h02};
        applyStimulus(w, 1'b0, 0, 1'b0);
        w = '{8'h03};
        applyStimulus(w, 1'b0, 0, 1'b0);
        waitIdle();
        checkOutput("ifg_exact", 32'(lastGap), 32'(IFG + 1));

        $display("[TB] bypass frames");
        logQ.delete(); logCyc.delete();
        watch = 1'b1;
        w = '{8'h5A};
        applyStimulus(w, 1'b1, 0, 1'b1);
        waitIdle();
        checkOutput("byp_accept", 32'(firstAcceptCyc - startCyc), 32'd1);
        checkOutput("byp_valid", 32'(firstValidCyc - startCyc), 32'd2);
        checkOutput("byp_size", 32'(logQ.size()), 32'd1);
        if (logQ.size() > 0) checkOutput("byp_word", 32'(logQ[0]), 32'({8'h5A, 1'b0, 1'b1}));
        w = '{8'h61, 8'h62, 8'h63};
        applyStimulus(w, 1'b1, 0, 1'b1);
        waitIdle();

        $display("[TB] asynchronous reset during preamble");
        checkEn = 1'b0;
        cfg_bypass = 1'b0;
        s_if.tdata = 8'h77; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        #3;
        checkOutput("pre_reset_valid", 32'({m_if.tvalid, busy}), 32'd3);
        aresetn = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        checkOutput("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(m_if.tdata), 32'd0);
        checkOutput("rst_tuser_tlast", 32'({m_if.tuser, m_if.tlast}), 32'd0);
        checkOutput("rst_busy_count", 32'({busy, s_if.tready, frame_count}), 32'd0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        checkEn = 1'b1;
        @(posedge aclk);
        #1;
        logQ.delete(); logCyc.delete();
        w = '{8'h77, 8'h88};
        applyStimulus(w, 1'b0, 0, 1'b0);
        waitIdle();
        n = 0;
        for (int i = 0; i < logQ.size() && logQ[i].data == 8'hAA; i++) n++;
        checkOutput("rst_full_preamble", 32'(n), 32'(PLEN));

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            readyPct = 30 + $urandom_range(70);
            w.delete();
            n = 1 + $urandom_range(5);
            for (int i = 0; i < n; i++) w.push_back(8'($urandom));
            applyStimulus(w, 1'($urandom_range(3) == 0), 30, 1'($urandom_range(1)));
        end
        waitIdle();
        readyPct = 100;

        $display("[TB] single-word preamble with 2-bit counter");
        for (int f = 0; f < 5; f++) begin
            prevB = frameCountB;
            sB_if.tdata = 8'(8'h60 + f);
            sB_if.tlast = 1'b1;
            sB_if.tvalid = 1'b1;
            n = 0;
            do begin
                @(negedge aclk);
                n++;
            end while (!sB_if.tready && n < 100);
            @(posedge aclk);
            #1;
            sB_if.tvalid = 1'b0;
            n = 0;
            while (frameCountB == prevB && n < 100) begin
                @(negedge aclk);
                n++;
            end
            checkOutput("small_count", 32'(frameCountB), 32'(smallCnt[f]));
        end
        checkOutput("small_size", 32'(logB.size()), 32'd15);
        for (int f = 0; f < 5 && logB.size() == 15; f++) begin
            checkOutput("small_pre", 32'(logB[3*f]), 32'({8'hAA, 1'b1, 1'b0}));
            checkOutput("small_sfd", 32'(logB[3*f+1]), 32'({8'hD5, 1'b1, 1'b0}));
            checkOutput("small_pay", 32'(logB[3*f+2]), 32'({8'(8'h60 + f), 1'b0, 1'b1}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/manchester_framer.md
# manchester_framer

Parametrised frame-header inserter for the Manchester TX path, placed between the payload AXI-Stream source and the Manchester encoder. Before each input frame it emits `PREAMBLE_LEN` preamble words and one start-frame-delimiter (SFD) word, then forwards the payload under full AXI-Stream backpressure. It enforces a programmable inter-frame gap and counts transmitted frames. A per-frame bypass mode forwards a frame with no header.

## Interface
- `DATA_WIDTH`, 8: stream word width.
- `PREAMBLE_LEN`, 3: preamble words per frame. Legal range 1..255.
- `PREAMBLE_WORD`, 8'hAA: preamble value, `DATA_WIDTH` bits.
- `SFD_WORD`, 8'hD5: start-frame-delimiter value, `DATA_WIDTH` bits.
- `IFG_LEN`, 2: extra idle cycles after each frame. Legal range 0..255.
- `CNT_WIDTH`, 16: width of the frame counter.

Ports:
- `aclk`  in  1  clock. This is the block's only clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  DATA_WIDTH  payload word.
- `s_axis_tvalid`  in  1  payload valid.
- `s_axis_tready`  out  1  payload accept.
- `s_axis_tlast`  in  1  last payload word of the frame.
- `m_axis_tdata`  out  DATA_WIDTH  output word.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  last word of the frame. Asserted only on payload words.
- `m_axis_tuser`  out  1  1 on preamble and SFD words, 0 on payload words.
- `cfg_bypass`  in  1  when 1, the frame is sent with no header. Sampled at frame start only.
- `frame_count`  out  CNT_WIDTH  number of completed frames, modulo 2^CNT_WIDTH.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, GAP.
- The m-side output is a single register (`tdata`/`tvalid`/`tlast`/`tuser`).
  - While `m_axis_tvalid && !m_axis_tready`, all m-side outputs hold stable.
  - A handshake is `tvalid && tready` in the same cycle.
- `s_axis_tready` is combinational: `(state==DATA) && !last_taken && (!m_axis_tvalid || m_axis_tready)`.
- IDLE:
  - Wait for `s_axis_tvalid`. The input word is not consumed in IDLE.
  - On `s_axis_tvalid`, latch `cfg_bypass`.
  - If bypass: go to DATA with the output register empty.
  - Otherwise: load `PREAMBLE_WORD` with tuser=1, set tvalid=1, set cnt=`PREAMBLE_LEN`-1, go to PREAMBLE.
- PREAMBLE, on each output handshake:
  - If cnt==0: load `SFD_WORD` (tuser=1) and go to SFD.
  - Otherwise: decrement cnt and keep the preamble word valid.
- SFD, on output handshake: clear tvalid and go to DATA.
- DATA:
  - On an input handshake, load the word into the output register with tlast copied and tuser=0.
  - If the accepted word has `s_axis_tlast`=1, set `last_taken`. This forces `s_axis_tready` to 0.
  - If there is an output handshake and no new input word, clear tvalid.
  - On the output handshake of the tlast word: increment `frame_count` (wraps to 0), clear `last_taken`, then go to GAP if `IFG_LEN`>0, else to IDLE.
- GAP: hold tvalid=0 for exactly `IFG_LEN` cycles, then go to IDLE.
- A `cfg_bypass` change during a frame has no effect until the next IDLE start.
- The block does not check frame content. A frame of one word with tlast=1 is legal.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `s_axis_tready`=0, `frame_count`=0, `busy`=0, state=IDLE, cnt=0, `last_taken`=0.
- Asynchronous reset mid-frame:
  - The partial frame is dropped and all outputs return to their reset values immediately.
  - Any remaining upstream words are treated as a new frame.
- Header latency, with `s_axis_tvalid` first high in IDLE at cycle 0 and `m_axis_tready`=1:
  - Preamble words valid in cycles 1..`PREAMBLE_LEN`.
  - SFD valid in cycle `PREAMBLE_LEN`+1.
  - Cycle `PREAMBLE_LEN`+2 is a bubble (tvalid=0). The first input word is accepted in this cycle.
  - First payload word valid in cycle `PREAMBLE_LEN`+3.
- Bypass latency: first input word accepted in cycle 1, valid on m in cycle 2.
- Throughput: one payload word per cycle when both sides are continuously ready.
- Inter-frame spacing: after the tlast output handshake in cycle t, at least `IFG_LEN`+1 cycles have tvalid=0 (GAP cycles plus the IDLE cycle). The next header word is valid no earlier than cycle t+`IFG_LEN`+2.
- Backpressure in PREAMBLE or SFD stalls cnt and holds the word. No header word is skipped or duplicated.

## Test plan
- Defaults, frame 11,22,33 (tlast on 33), `m_axis_tready`=1 → m sequence AA,AA,AA,D5,11,22,33. tuser=1,1,1,1,0,0,0. tlast only on 33. `frame_count`=1.
- Same frame with `m_axis_tready` toggling at random → identical word sequence. Outputs stable during every stall. No word lost or duplicated.
- Two back-to-back frames, `IFG_LEN`=2 → exactly 3 cycles of tvalid=0 between the first frame's tlast handshake and the second frame's first AA.
- `cfg_bypass`=1, one-word frame 5A with tlast → m emits only 5A with tuser=0, tlast=1, valid in cycle 2. Toggling `cfg_bypass` mid-frame has no effect.
- `PREAMBLE_LEN`=1, `CNT_WIDTH`=2, 5 frames → one AA before each D5. `frame_count` reads 1,2,3,0,1.
- `aresetn` pulsed low during the second preamble word → all outputs return to reset values asynchronously. The next frame starts with a full preamble.
